mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the processor datapath. It consumes the two source operands read from the register bank and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over a fixed number of cycles. It returns the 32-bit result together with the destination register index and a write strobe, which drive the register bank's write port (`wd3`/`a3`/`we`). The control unit holds the pipeline while `busy` is high.

---
 rtl/mul_div_unit.sv | 136 +++++++++++++
 tb/tb_mul_div_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, fixed 33-cycle latency.
// The result, destination index and write strobe drive the register bank write port.
module mul_div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_MD,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            we_out
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e state_q, state_d;

    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   mag_a_q;   // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [XLEN-1:0]   mag_b_q;   // multiplicand or divisor
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   rem_q;
    logic [5:0]        cnt_q;
    logic              neg_q;
    logic              neg_rem_q;
    logic              div0_q;
    logic [XLEN-1:0]   result_q;

    logic            a_signed, b_signed, sign_a, sign_b, accept, last_iter;
    logic [XLEN-1:0] abs_a, abs_b;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sign_a   = a_signed && op_a[XLEN-1];
        sign_b   = b_signed && op_b[XLEN-1];
        abs_a    = sign_a ? -op_a : op_a;
        abs_b    = sign_b ? -op_b : op_b;
        accept   = (state_q == StIdle) && start;
        last_iter = (state_q == StCalc) && (cnt_q == 6'(XLEN - 1));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StCalc;
            StCalc: if (last_iter) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset_MD) begin
        if (reset_MD) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // One iteration of either algorithm, plus the final sign/special-case fix-up.
    logic [XLEN:0]     mul_sum, shifted;
    logic [XLEN-1:0]   diff, rem_n, mag_a_n, quo, rem_s;
    logic [2*XLEN-1:0] acc_n, prod;
    logic              fits;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (mag_a_q[0] ? mag_b_q : '0)};
        acc_n   = (2*XLEN)'({mul_sum, acc_q[XLEN-1:0]} >> 1);
        shifted = {rem_q, mag_a_q[XLEN-1]};
        fits    = shifted >= {1'b0, mag_b_q};
        diff    = XLEN'(shifted - {1'b0, mag_b_q});
        rem_n   = fits ? diff : shifted[XLEN-1:0];
        mag_a_n = op_q[2] ? {mag_a_q[XLEN-2:0], fits} : (mag_a_q >> 1);

        prod  = neg_q ? -acc_n : acc_n;
        quo   = neg_q ? -mag_a_n : mag_a_n;
        rem_s = neg_rem_q ? -rem_n : rem_n;
        final_res = '0;
        unique case (op_q)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = div0_q ? '1 : quo;
            3'b110, 3'b111:         final_res = rem_s;
            default:                final_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset_MD) begin
        if (reset_MD) begin
            op_q      <= '0;
            rd_q      <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            result_q  <= '0;
        end else if (accept) begin
            op_q      <= funct3;
            rd_q      <= rd_in;
            mag_a_q   <= abs_a;
            mag_b_q   <= abs_b;
            acc_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            div0_q    <= (op_b == '0);
        end else if (state_q == StCalc) begin
            mag_a_q <= mag_a_n;
            acc_q   <= acc_n;
            rem_q   <= rem_n;
            cnt_q   <= cnt_q + 6'd1;
            if (last_iter) result_q <= final_res;
        end
    end

    always_comb begin
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
        result = result_q;
        rd_out = rd_q;
        we_out = done && (rd_q != 5'd0);
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed scoreboard bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset_MD, start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done, we_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    mul_div_unit #(.XLEN(32)) dut (
        .clk(clk), .reset_MD(reset_MD), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out), .we_out(we_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint p;
        case (f)
            3'd0: p = ua * ub;
            3'd1: p = sa * sb;
            3'd2: p = sa * ub;
            3'd3: p = ua * ub;
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = ua / ub;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = sa % sb;
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
            end
        endcase
        if (f == 3'd1 || f == 3'd2 || f == 3'd3) return p[63:32];
        return p[31:0];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor; latency counts edges from accept (E0) to the done cycle (after E32).
    exp_t mon_e;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (prev_done) check("done_pulse", 32'(done), 32'd0);
        else if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 required no pending op");
            end else begin
                mon_e = exp_q.pop_front();
                check("result", result, mon_e.res);
                check("rd_out", 32'(rd_out), 32'(mon_e.rd));
                check("we_out", 32'(we_out), 32'(mon_e.rd != 5'd0));
                check("latency", 32'(cyc - mon_e.t0), 32'd32);
            end
        end
        prev_done <= done;
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 required busy=0");
            return;
        end
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'($urandom);
        rd_in  = 5'($urandom);
        exp_q.push_back(exp_t'{model(f, a, b), rd, cyc});
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    initial begin
        int n;
        reset_MD = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_we", 32'(we_out), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd", 32'(rd_out), 32'd0);
        @(negedge clk);
        reset_MD = 1'b0;

        issue(3'd0, 32'd7, 32'd6, 5'd5);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
        issue(3'd2, 32'hFFFFFFFF, 32'd2, 5'd3);
        issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4);
        issue(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6);
        issue(3'd5, 32'd100, 32'd7, 5'd7);
        issue(3'd7, 32'd100, 32'd7, 5'd8);
        issue(3'd5, 32'd5, 32'd0, 5'd9);
        issue(3'd6, 32'd5, 32'd0, 5'd10);
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11);
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12);
        issue(3'd0, 32'd9, 32'd9, 5'd0);

        // A start pulse mid-operation must not spawn a second done.
        issue(3'd0, 32'd12, 32'd13, 5'd13);
        repeat (10) @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd1; op_b = 32'd1; rd_in = 5'd3;
        @(negedge clk);
        start = 1'b0;

        // A start coinciding with done is not accepted.
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_in_done_ignored", 32'(busy), 32'd0);

        for (int i = 0; i < 200; i++)
            issue(3'($urandom), pick(), pick(), 5'($urandom));

        // Asynchronous reset during iteration 17 discards the operation.
        issue(3'd0, 32'd5, 32'd5, 5'd7);
        repeat (17) @(posedge clk);
        #2 reset_MD = 1'b1;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_we", 32'(we_out), 32'd0);
        check("midreset_result", result, 32'd0);
        check("midreset_rd", 32'(rd_out), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset_MD = 1'b0;
        issue(3'd0, 32'd3, 32'd3, 5'd8);

        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
